muldiv_iter: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a parametrised operand width. It sits beside the ALU in the execute stage of the next-generation core, which must now stall on long-latency instructions. It uses a start/busy/done handshake. It computes one quotient or product bit per cycle with a shift-add / restoring-divide datapath.

---
 rtl/muldiv_iter.sv | 153 +++++++++++++++
 tb/tb_muldiv_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide unit, one product or quotient bit per cycle
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FAST, S_DONE} state_t;
    state_t state, state_n;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opm;
    logic [2:0]         op;
    logic               neg_q, neg_r;

    logic             is_div, a_signed, b_signed, sa, sb;
    logic             div_zero, div_ovf, fast;
    logic [WIDTH-1:0] mag_a, mag_b, fast_res;

    // Operand decode at issue: magnitudes, result signs and the divide special cases.
    always_comb begin
        is_div   = funct3[2];
        a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        sa       = a_signed & a[WIDTH-1];
        sb       = b_signed & b[WIDTH-1];
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && !funct3[0] && (a == MIN_NEG) && (b == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            fast_res = funct3[1] ? a : '1;
        end else begin
            fast_res = funct3[1] ? '0 : a;
        end
    end

    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    // acc holds {high, low}: product/multiplier for multiply, remainder/dividend-quotient for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opm} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opm};
        div_diff  = div_shift[WIDTH-1:0] - opm;
        if (op[2]) begin
            acc_step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, calc_res;

    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        quo  = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem  = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        case (op)
            3'b000:                 calc_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         calc_res = quo;
            default:                calc_res = rem;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = fast ? S_FAST : S_CALC;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else if (count == '0) begin
                    state_n = S_DONE;
                end
            end
            S_FAST:  state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            count  <= '0;
            acc    <= '0;
            opm    <= '0;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op    <= funct3;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        count <= CW'(WIDTH - 1);
                        opm   <= is_div ? mag_b : mag_a;
                        if (fast) begin
                            acc <= {{WIDTH{1'b0}}, fast_res};
                        end else begin
                            acc <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        acc   <= acc_step;
                        count <= count - CW'(1);
                        if (count == '0) begin
                            result <= calc_res;
                        end
                    end
                end
                S_FAST: result <= acc[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Both handshake outputs come straight from the state register.
    assign busy = (state == S_CALC) || (state == S_FAST);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - scoreboard bench for muldiv_iter at WIDTH 32 and WIDTH 8
module tb_muldiv_iter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start32 = 1'b0, flush32 = 1'b0;
    logic [2:0]  f32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [31:0] res32;

    logic        start8 = 1'b0, flush8 = 1'b0;
    logic [2:0]  f8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [7:0]  res8;

    muldiv_iter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .flush(flush32), .funct3(f32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .result(res32)
    );

    muldiv_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .flush(flush8), .funct3(f8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    typedef struct {
        string       tag;
        logic [31:0] exp;
        int          lat;
        int          acc_cyc;
    } sb_t;

    sb_t q32[$];
    sb_t q8[$];
    int  busy_cnt32 = 0;
    int  done_cnt32 = 0;

    always @(negedge clk) begin
        if (busy32) busy_cnt32++;
        if (reset && done32) begin
            sb_t e;
            done_cnt32++;
            if (q32.size() == 0) begin
                check_eq("unexpected_done32", 32'd1, 32'd0);
            end else begin
                e = q32.pop_front();
                check_eq({e.tag, "_res"}, res32, e.exp);
                check_eq({e.tag, "_lat"}, cyc - e.acc_cyc + 1, e.lat);
                check_eq({e.tag, "_excl"}, 32'(busy32), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && done8) begin
            sb_t e;
            if (q8.size() == 0) begin
                check_eq("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check_eq({e.tag, "_res"}, 32'(res8), e.exp);
                check_eq({e.tag, "_lat"}, cyc - e.acc_cyc + 1, e.lat);
            end
        end
    end

    task automatic issue(input int w, input string tag, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit fast, input bit hold);
        sb_t e;
        @(negedge clk);
        if (w == 32) begin
            f32 = f; a32 = a; b32 = b; start32 = 1'b1;
        end else begin
            f8 = f; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        e.tag = tag;
        e.exp = exp;
        e.lat = fast ? 2 : w + 1;
        e.acc_cyc = cyc;
        if (w == 32) begin
            q32.push_back(e);
            if (!hold) start32 = 1'b0;
        end else begin
            q8.push_back(e);
            start8 = 1'b0;
        end
    endtask

    task automatic drain(input int w, input string tag);
        int n = 0;
        while (((w == 32) ? q32.size() : q8.size()) != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_drain"}, (w == 32) ? q32.size() : q8.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic run(input int w, input string tag, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit fast);
        issue(w, tag, f, a, b, exp, fast, 1'b0);
        drain(w, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sb_t e2;
        int  n;
        int  dc;

        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy32), 32'd0);
        check_eq("rst_done", 32'(done32), 32'd0);
        check_eq("rst_result", res32, 32'd0);
        check_eq("rst_result8", 32'(res8), 32'd0);
        reset = 1'b1;
        busy_cnt32 = 0;

        run(32, "mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        check_eq("mul_busy_cycles", busy_cnt32, 32'd32);
        run(32, "mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        run(32, "mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run(32, "mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0);
        run(32, "div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
        run(32, "rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
        run(32, "divu", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        run(32, "remu", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
        run(32, "divu_z", 3'b101, 32'h1234, 32'd0, 32'hFFFFFFFF, 1'b1);
        run(32, "remu_z", 3'b111, 32'h1234, 32'd0, 32'h1234, 1'b1);
        run(32, "div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run(32, "rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1);

        run(32, "divu_pre", 3'b101, 32'd1000, 32'd10, 32'd100, 1'b0);
        @(negedge clk);
        f32 = 3'b000; a32 = 32'd5; b32 = 32'd6; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        flush32 = 1'b1;
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        check_eq("flush_busy", 32'(busy32), 32'd0);
        check_eq("flush_result", res32, 32'd100);
        dc = done_cnt32;
        repeat (40) @(negedge clk);
        check_eq("flush_no_done", done_cnt32 - dc, 32'd0);

        issue(32, "ignore", 3'b101, 32'd1000, 32'd7, 32'd142, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        f32 = 3'b000; a32 = 32'd5; b32 = 32'd5; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        drain(32, "ignore");

        issue(32, "b2b1", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 1'b1);
        n = 0;
        while (!done32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("b2b_done_seen", 32'(done32), 32'd1);
        a32 = 32'd6; b32 = 32'd7;
        @(posedge clk);
        #1;
        e2.tag = "b2b2"; e2.exp = 32'd42; e2.lat = 33; e2.acc_cyc = cyc;
        q32.push_back(e2);
        start32 = 1'b0;
        check_eq("b2b_no_gap", 32'(busy32), 32'd1);
        drain(32, "b2b");

        @(negedge clk);
        f32 = 3'b100; a32 = 32'hFFFFFFF9; b32 = 32'd2; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("areset_busy", 32'(busy32), 32'd0);
        check_eq("areset_done", 32'(done32), 32'd0);
        check_eq("areset_result", res32, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run(8, "mulhu8", 3'b011, 32'hFF, 32'hFF, 32'hFE, 1'b0);
        run(8, "mul8", 3'b000, 32'h07, 32'hFD, 32'hEB, 1'b0);
        run(8, "div8", 3'b100, 32'hF9, 32'h02, 32'hFD, 1'b0);
        run(8, "rem8", 3'b110, 32'hF9, 32'h02, 32'hFF, 1'b0);
        run(8, "divu8", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        run(8, "divu_z8", 3'b101, 32'h12, 32'h00, 32'hFF, 1'b1);
        run(8, "div_ovf8", 3'b100, 32'h80, 32'hFF, 32'h80, 1'b1);
        run(8, "rem_ovf8", 3'b110, 32'h80, 32'hFF, 32'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
